// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Push-button conditioner. The raw pin is normalised so that
//               1 means pressed, passed through a 2-FF synchroniser and a
//               stable-count debounce filter, and then tracked by a press FSM.
//               The FSM emits one-cycle press, release and long-press pulses
//               and a held-level flag.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 6000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_held
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic              w_pin;
  logic              r_s1;
  logic              r_s2;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_level;
  logic              w_update;
  logic              w_rise;
  logic              w_fall;

  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_next;
  logic              w_press;
  logic              w_release;
  logic              w_long;
  logic              w_held;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_held;

  // Pressed is always 1 internally, whatever the board polarity.
  assign w_pin = i_btn ^ ACTIVE_LOW;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_pin;
      r_s2 <= r_s1;
    end
  end

  // The filter accepts a new level on the edge that completes the stable run,
  // so rise/fall are known combinationally and the FSM can register its
  // pulses on the same edge that o_level changes.
  assign w_update = (r_s2 != r_level) && (r_cnt == C_CNT_LAST);
  assign w_rise   = w_update &&  r_s2;
  assign w_fall   = w_update && !r_s2;

  // Debounce filter: any sample agreeing with the current level restarts the run.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_s2 == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == C_CNT_LAST) begin
      r_level <= r_s2;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Press FSM state, hold counter and registered event outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_RELEASED;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_press    <= w_press;
      r_release  <= w_release;
      r_long     <= w_long;
      r_held     <= w_held;
    end
  end

  // Next-state and event decode; a fall beats the long-press threshold.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_press      = 1'b0;
    w_release    = 1'b0;
    w_long       = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (w_rise) begin
          w_state_next = ST_PRESSED;
          w_press      = 1'b1;
          w_hold_next  = '0;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_state_next = ST_RELEASED;
          w_release    = 1'b1;
        end else if (r_hold_cnt == C_HOLD_LAST) begin
          w_state_next = ST_HELD;
          w_long       = 1'b1;
        end else begin
          w_hold_next  = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        if (w_fall) begin
          w_state_next = ST_RELEASED;
          w_release    = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RELEASED;
      end
    endcase
    // Held flag follows the long-press pulse and drops with the release pulse.
    w_held = (r_state == ST_HELD) && (w_state_next == ST_HELD);
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long;
  assign o_held       = r_held;

endmodule
`default_nettype wire
